// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, external stall and branch flush.
// Define WB_BYPASS_EN to forward same-cycle write-back data into the latched operands.
module id_ex_stage_reg #(
  parameter int CTRL_W    = 8,
  parameter int BUB_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [4:0]           rs_addr_i,
  input  logic [4:0]           rt_addr_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 use_rs_i,
  input  logic                 use_rt_i,
  input  logic [31:0]          rs_data_i,
  input  logic [31:0]          rt_data_i,
  input  logic [31:0]          imm_i,
  input  logic                 mem_read_i,
  input  logic                 reg_write_i,
  input  logic [CTRL_W-1:0]    ctrl_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [31:0]          wb_data_i,
  input  logic                 wb_we_i,
  output logic                 ex_valid_o,
  output logic [4:0]           ex_rs_addr_o,
  output logic [4:0]           ex_rt_addr_o,
  output logic [4:0]           ex_rd_addr_o,
  output logic [31:0]          ex_rs_data_o,
  output logic [31:0]          ex_rt_data_o,
  output logic [31:0]          ex_imm_o,
  output logic                 ex_mem_read_o,
  output logic                 ex_reg_write_o,
  output logic [CTRL_W-1:0]    ex_ctrl_o,
  output logic                 hazard_stall_o,
  output logic                 front_hold_o,
  output logic [BUB_CNT_W-1:0] bubble_cnt_o
);

  localparam logic [BUB_CNT_W-1:0] CNT_ONE = BUB_CNT_W'(1);

  logic                 hazard;
  logic                 bubble;
  logic [31:0]          rsOperand;
  logic [31:0]          rtOperand;
  logic [BUB_CNT_W-1:0] bubbleCntNext;

  // A load in EX whose destination (rt) is read by the ID instruction cannot be forwarded in time.
  always_comb begin
    hazard = ex_valid_o & ex_mem_read_o & (ex_rt_addr_o != 5'd0)
           & ((use_rs_i & (rs_addr_i == ex_rt_addr_o))
            | (use_rt_i & (rt_addr_i == ex_rt_addr_o)));
  end

  assign hazard_stall_o = hazard & ~flush_i;
  assign front_hold_o   = hazard_stall_o | stall_i;
  assign bubble         = flush_i | hazard;
  assign bubbleCntNext  = (&bubble_cnt_o) ? bubble_cnt_o : bubble_cnt_o + CNT_ONE;

  always_comb begin
    rsOperand = rs_data_i;
    rtOperand = rt_data_i;
`ifdef WB_BYPASS_EN
    if (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == rs_addr_i)) rsOperand = wb_data_i;
    if (wb_we_i && (wb_addr_i != 5'd0) && (wb_addr_i == rt_addr_i)) rtOperand = wb_data_i;
`endif
    // $0 reads as zero whatever the register file presents.
    if (rs_addr_i == 5'd0) rsOperand = '0;
    if (rt_addr_i == 5'd0) rtOperand = '0;
  end

`ifndef WB_BYPASS_EN
  logic unusedWb;
  assign unusedWb = ^{wb_addr_i, wb_data_i, wb_we_i};
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_o     <= 1'b0;
      ex_rs_addr_o   <= '0;
      ex_rt_addr_o   <= '0;
      ex_rd_addr_o   <= '0;
      ex_rs_data_o   <= '0;
      ex_rt_data_o   <= '0;
      ex_imm_o       <= '0;
      ex_mem_read_o  <= 1'b0;
      ex_reg_write_o <= 1'b0;
      ex_ctrl_o      <= '0;
      bubble_cnt_o   <= '0;
    end else if (stall_i) begin
      ex_valid_o <= ex_valid_o;
    end else if (bubble) begin
      ex_valid_o     <= 1'b0;
      ex_rs_addr_o   <= '0;
      ex_rt_addr_o   <= '0;
      ex_rd_addr_o   <= '0;
      ex_rs_data_o   <= '0;
      ex_rt_data_o   <= '0;
      ex_imm_o       <= '0;
      ex_mem_read_o  <= 1'b0;
      ex_reg_write_o <= 1'b0;
      ex_ctrl_o      <= '0;
      bubble_cnt_o   <= bubbleCntNext;
    end else begin
      ex_valid_o     <= 1'b1;
      ex_rs_addr_o   <= rs_addr_i;
      ex_rt_addr_o   <= rt_addr_i;
      ex_rd_addr_o   <= rd_addr_i;
      ex_rs_data_o   <= rsOperand;
      ex_rt_data_o   <= rtOperand;
      ex_imm_o       <= imm_i;
      ex_mem_read_o  <= mem_read_i;
      ex_reg_write_o <= reg_write_i;
      ex_ctrl_o      <= ctrl_i;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed hazard/flush/stall/bypass scenarios plus random traffic,
// checked against a reference model through an expected-result queue.
module tb_id_ex_stage_reg;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic             valid;
    logic [4:0]       rsA;
    logic [4:0]       rtA;
    logic [4:0]       rdA;
    logic [31:0]      rsD;
    logic [31:0]      rtD;
    logic [31:0]      imm;
    logic             mr;
    logic             rw;
    logic [CTRL_W-1:0] ctrl;
    logic [CNT_W-1:0] cnt;
  } ex_t;
  localparam int EXP_W = $bits(ex_t);

  logic clk_i = 1'b0;
  logic rst_i, stall_i, flush_i;
  logic [4:0] rs_addr_i, rt_addr_i, rd_addr_i, wb_addr_i;
  logic use_rs_i, use_rt_i, mem_read_i, reg_write_i, wb_we_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i, wb_data_i;
  logic [CTRL_W-1:0] ctrl_i;
  logic ex_valid_o, ex_mem_read_o, ex_reg_write_o, hazard_stall_o, front_hold_o;
  logic [4:0] ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
  logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  logic [EXP_W-1:0] exp_q[$];
  ex_t mdl;
  int n_checks = 0;
  int n_fail = 0;

  id_ex_stage_reg #(.CTRL_W(CTRL_W), .BUB_CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .use_rs_i(use_rs_i), .use_rt_i(use_rt_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .mem_read_i(mem_read_i), .reg_write_i(reg_write_i), .ctrl_i(ctrl_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .wb_we_i(wb_we_i),
    .ex_valid_o(ex_valid_o), .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o), .ex_mem_read_o(ex_mem_read_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_ctrl_o(ex_ctrl_o), .hazard_stall_o(hazard_stall_o), .front_hold_o(front_hold_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_ex(input ex_t e);
    check_eq("ex_valid", 32'(ex_valid_o), 32'(e.valid));
    check_eq("ex_rs_addr", 32'(ex_rs_addr_o), 32'(e.rsA));
    check_eq("ex_rt_addr", 32'(ex_rt_addr_o), 32'(e.rtA));
    check_eq("ex_rd_addr", 32'(ex_rd_addr_o), 32'(e.rdA));
    check_eq("ex_rs_data", ex_rs_data_o, e.rsD);
    check_eq("ex_rt_data", ex_rt_data_o, e.rtD);
    check_eq("ex_imm", ex_imm_o, e.imm);
    check_eq("ex_mem_read", 32'(ex_mem_read_o), 32'(e.mr));
    check_eq("ex_reg_write", 32'(ex_reg_write_o), 32'(e.rw));
    check_eq("ex_ctrl", 32'(ex_ctrl_o), 32'(e.ctrl));
    check_eq("bubble_cnt", 32'(bubble_cnt_o), 32'(e.cnt));
  endtask

  task automatic idle_inputs();
    stall_i = 0; flush_i = 0; rs_addr_i = 0; rt_addr_i = 0; rd_addr_i = 0;
    use_rs_i = 0; use_rt_i = 0; rs_data_i = 0; rt_data_i = 0; imm_i = 0;
    mem_read_i = 0; reg_write_i = 0; ctrl_i = 0; wb_addr_i = 0; wb_data_i = 0; wb_we_i = 0;
  endtask

  function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (wb_we_i && wb_addr_i == a) return wb_data_i;
`endif
    return d;
  endfunction

  // Called just after a negedge with ID inputs already driven; ends at the following negedge.
  task automatic step();
    ex_t nxt;
    logic hz;
    #1;
    hz = mdl.valid & mdl.mr & (mdl.rtA != 5'd0)
       & ((use_rs_i & (rs_addr_i == mdl.rtA)) | (use_rt_i & (rt_addr_i == mdl.rtA)));
    check_eq("hazard_stall", 32'(hazard_stall_o), 32'(hz & ~flush_i));
    check_eq("front_hold", 32'(front_hold_o), 32'((hz & ~flush_i) | stall_i));
    if (stall_i) nxt = mdl;
    else if (flush_i || hz) begin
      nxt = '0;
      nxt.cnt = (mdl.cnt == '1) ? mdl.cnt : mdl.cnt + 1'b1;
    end else begin
      nxt.valid = 1'b1;
      nxt.rsA = rs_addr_i; nxt.rtA = rt_addr_i; nxt.rdA = rd_addr_i;
      nxt.rsD = model_operand(rs_addr_i, rs_data_i);
      nxt.rtD = model_operand(rt_addr_i, rt_data_i);
      nxt.imm = imm_i; nxt.mr = mem_read_i; nxt.rw = reg_write_i; nxt.ctrl = ctrl_i;
      nxt.cnt = mdl.cnt;
    end
    exp_q.push_back(nxt);
    mdl = nxt;
    @(posedge clk_i); #1;
    compare_ex(ex_t'(exp_q.pop_front()));
    @(negedge clk_i);
  endtask

  initial begin
    // reset
    idle_inputs();
    rst_i = 0;
    mdl = '0;
    rs_data_i = 32'hFFFF_FFFF; rt_addr_i = 5'd9; flush_i = 1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    compare_ex('0);
    idle_inputs();
    rst_i = 1;
    #1 check_eq("reset_front_hold", 32'(front_hold_o), 32'd0);
    step();

    // plain load
    rs_addr_i = 3; rs_data_i = 32'h11; rt_addr_i = 4; rt_data_i = 32'h22; rd_addr_i = 5;
    use_rs_i = 1; use_rt_i = 1; reg_write_i = 1; imm_i = 32'hFFFF_FFF0; ctrl_i = 8'h5A;
    step();
    check_eq("load_rs_data", ex_rs_data_o, 32'h11);
    check_eq("load_rd_addr", 32'(ex_rd_addr_o), 32'd5);

    // load-use on rs
    idle_inputs();
    rt_addr_i = 8; mem_read_i = 1; reg_write_i = 1; use_rs_i = 1; rs_addr_i = 2;
    step();
    idle_inputs();
    rs_addr_i = 8; use_rs_i = 1; rt_addr_i = 9; rd_addr_i = 10; reg_write_i = 1;
    rs_data_i = 32'hABC; ctrl_i = 8'h3;
    step();
    check_eq("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
    check_eq("lu_bubble_cnt", 32'(bubble_cnt_o), 32'd1);
    step();
    check_eq("lu_add_loaded", 32'(ex_rd_addr_o), 32'd10);

    // load-use through rt, and no hazard when the load targets $0
    idle_inputs();
    rt_addr_i = 6; mem_read_i = 1; step();
    idle_inputs(); rt_addr_i = 6; use_rt_i = 1; step();
    step();
    idle_inputs(); rt_addr_i = 0; mem_read_i = 1; step();
    idle_inputs(); rs_addr_i = 0; use_rs_i = 1; step();
    check_eq("r0_no_bubble", 32'(ex_valid_o), 32'd1);

    // flush clears control
    idle_inputs();
    flush_i = 1; ctrl_i = 8'hFF; reg_write_i = 1; mem_read_i = 1; rs_addr_i = 1; rs_data_i = 7;
    step();
    check_eq("flush_ctrl", 32'(ex_ctrl_o), 32'd0);

    // flush together with a hazard: one bubble
    idle_inputs(); rt_addr_i = 8; mem_read_i = 1; step();
    idle_inputs(); rs_addr_i = 8; use_rs_i = 1; flush_i = 1; step();

    // stall with flush holds everything
    idle_inputs(); rs_addr_i = 12; rs_data_i = 32'h1234; rd_addr_i = 13; ctrl_i = 8'h81; step();
    idle_inputs(); stall_i = 1; flush_i = 1; rs_addr_i = 3; rs_data_i = 32'h99;
    repeat (3) step();
    check_eq("stall_hold_rs", ex_rs_data_o, 32'h1234);

    // write-back bypass
    idle_inputs();
    wb_we_i = 1; wb_addr_i = 7; wb_data_i = 32'hDEAD; rs_addr_i = 7; rs_data_i = 32'h1;
    step();
`ifdef WB_BYPASS_EN
    check_eq("bypass_rs", ex_rs_data_o, 32'hDEAD);
`else
    check_eq("bypass_rs", ex_rs_data_o, 32'h1);
`endif
    idle_inputs();
    wb_we_i = 1; wb_addr_i = 0; wb_data_i = 32'hDEAD; rs_addr_i = 0; rs_data_i = 32'h5;
    rt_addr_i = 0; rt_data_i = 32'h6;
    step();
    check_eq("bypass_r0", ex_rs_data_o, 32'h0);

    // counter saturation
    idle_inputs(); flush_i = 1;
    repeat (20) step();
    check_eq("cnt_saturated", 32'(bubble_cnt_o), 32'd15);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      rs_addr_i = 5'($urandom_range(0, 3));
      rt_addr_i = 5'($urandom_range(0, 3));
      rd_addr_i = 5'($urandom_range(0, 31));
      use_rs_i = 1'($urandom_range(0, 1));
      use_rt_i = 1'($urandom_range(0, 1));
      rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
      mem_read_i = ($urandom_range(0, 2) == 0);
      reg_write_i = 1'($urandom_range(0, 1));
      ctrl_i = 8'($urandom_range(0, 255));
      wb_we_i = 1'($urandom_range(0, 1));
      wb_addr_i = 5'($urandom_range(0, 3));
      wb_data_i = $urandom;
      step();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
